// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port arbiter and sequencer for the shared signed multi-cycle
// multiplier. It accepts one request at a time and pulses the multiplier start.
// It follows the multiplier busy window and returns the product to the winning
// port as a one-cycle response pulse.
// Build option: define MULT_ARB_RR_EN for round-robin arbitration. When it is
// undefined, arbitration is fixed priority and port 0 always wins.
module mult_arbiter #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic signed [WIDTH-1:0]   req_a0,
    input  logic signed [WIDTH-1:0]   req_b0,
    input  logic signed [WIDTH-1:0]   req_a1,
    input  logic signed [WIDTH-1:0]   req_b1,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic signed [2*WIDTH-1:0] rsp_data,
    output logic                      mult_execute,
    output logic signed [WIDTH-1:0]   mult_val1,
    output logic signed [WIDTH-1:0]   mult_val2,
    input  logic                      mult_busy,
    input  logic signed [2*WIDTH-1:0] mult_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    // The cycle in which busy is first seen low counts as the first settle
    // cycle. The SETTLE state therefore covers only the remaining SETTLE-1
    // cycles, and the counter is loaded with SETTLE-2.
    localparam logic [7:0] SETTLE_LOAD = 8'((SETTLE > 2) ? (SETTLE - 2) : 0);

    state_t     state;
    state_t     state_next;
    logic       grant;
    logic       accept;
    logic       owner;
    logic [7:0] settle_cnt;

`ifdef MULT_ARB_RR_EN
    logic       rr_ptr;

    // Round-robin pointer: after every accept it points at the port that lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant;
        end
    end
`endif

    // Pick the winning port among the valid requesters.
    always_comb begin
        grant = 1'b0;
`ifdef MULT_ARB_RR_EN
        if (req_valid[rr_ptr]) begin
            grant = rr_ptr;
        end else begin
            grant = ~rr_ptr;
        end
`else
        if (!req_valid[0]) begin
            grant = 1'b1;
        end
`endif
    end

    // Accept only in IDLE. Ready is suppressed during reset so no requester
    // sees a handshake that the reset then discards.
    always_comb begin
        accept    = (state == S_IDLE) && !reset && (req_valid != 2'b00);
        req_ready = accept ? (2'b01 << grant) : 2'b00;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state: issue, wait for busy to rise, run until it falls,
    // settle, then return the product.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (accept) state_next = S_ISSUE;
            S_ISSUE:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (mult_busy) state_next = S_RUN;
            S_RUN:       if (!mult_busy) state_next = (SETTLE > 1) ? S_SETTLE : S_DONE;
            S_SETTLE:    if (settle_cnt == 8'd0) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Latch the operands and the owner on accept. Start the multiplier in the
    // following cycle, which is the ISSUE state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult_execute <= 1'b0;
            mult_val1    <= '0;
            mult_val2    <= '0;
            owner        <= 1'b0;
        end else begin
            mult_execute <= accept;
            if (accept) begin
                owner     <= grant;
                mult_val1 <= grant ? req_a1 : req_a0;
                mult_val2 <= grant ? req_b1 : req_b0;
            end
        end
    end

    // Settle counter: loaded as busy falls, counted down inside SETTLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= 8'd0;
        end else if (state == S_RUN && !mult_busy) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == S_SETTLE && settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

    // Response: capture the product in DONE and pulse the owner's valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (state == S_DONE) begin
                rsp_data  <= mult_out;
                rsp_valid <= 2'b01 << owner;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural
// multiplier model. Expected grants, products and latencies come from a
// reference model. That model tracks one in-flight multiply and the
// arbitration preference.
module tb_mult_arbiter;
    localparam int W   = 16;
    localparam int LAT = 36;
`ifdef MULT_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic signed [W-1:0]   req_a0, req_b0, req_a1, req_b1;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic signed [2*W-1:0] rsp_data;
    logic                  mult_execute;
    logic signed [W-1:0]   mult_val1, mult_val2;
    logic                  mult_busy = 1'b0;
    logic signed [2*W-1:0] mult_out  = '0;

    mult_arbiter #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mult_execute(mult_execute),
        .mult_val1(mult_val1), .mult_val2(mult_val2),
        .mult_busy(mult_busy), .mult_out(mult_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic signed [W-1:0] a; logic signed [W-1:0] b; } op_t;
    typedef struct { int port; logic [31:0] prod; int acc_cyc; int lat; } exp_t;

    op_t  opq0[$];
    op_t  opq1[$];
    exp_t sb[$];
    int   order_log[$];
    int   acc_log[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, extra = 0;
    int n_accepts = 0, aborted = 0, rsp_seen = 0;
    int exec_seen = 0, exec_expected = 0, last_acc_cyc = -10;
    bit in_flight = 1'b0;
    int pref = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] ref_prod(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        return 32'(ia * ib);
    endfunction

    function automatic logic signed [W-1:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            2:       return -16'sd1;
            default: return 16'($urandom);
        endcase
    endfunction

    // Multiplier model: busy rises 'extra' cycles after the usual one-cycle
    // start latency, stays high 32 cycles, and the product appears as busy falls.
    int   run_cnt = 0, dly_cnt = 0;
    logic pend = 1'b0;
    logic signed [31:0] mprod = '0;
    always @(posedge clk) begin
        longint p;
        if (reset) begin
            mult_busy <= 1'b0;
            pend      <= 1'b0;
            run_cnt   <= 0;
            dly_cnt   <= 0;
        end else if (mult_execute) begin
            p = longint'(mult_val1) * longint'(mult_val2);
            mprod    <= p[31:0];
            mult_out <= 32'($urandom);
            if (extra == 0) begin
                mult_busy <= 1'b1;
                run_cnt   <= 31;
            end else begin
                pend    <= 1'b1;
                dly_cnt <= extra - 1;
            end
        end else if (pend) begin
            if (dly_cnt == 0) begin
                pend      <= 1'b0;
                mult_busy <= 1'b1;
                run_cnt   <= 31;
            end else begin
                dly_cnt <= dly_cnt - 1;
            end
        end else if (mult_busy) begin
            if (run_cnt == 0) begin
                mult_busy <= 1'b0;
                mult_out  <= mprod;
            end else begin
                run_cnt <= run_cnt - 1;
            end
        end
    end

    // Requesters: each port presents the head of its queue until it is accepted.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            req_valid[0] = (opq0.size() != 0);
            if (opq0.size() != 0) begin
                req_a0 = opq0[0].a;
                req_b0 = opq0[0].b;
            end
            req_valid[1] = (opq1.size() != 0);
            if (opq1.size() != 0) begin
                req_a1 = opq1[0].a;
                req_b1 = opq1[0].b;
            end
        end
    end

    // Monitor: checks responses against the scoreboard and ready against the
    // reference arbitration, and records accepts into the scoreboard.
    always @(negedge clk) begin
        int   g;
        logic [1:0] exp_rdy;
        if (reset) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            aborted  += sb.size();
            sb.delete();
            in_flight = 1'b0;
            pref      = 0;
        end else begin
            if (rsp_valid != 2'b00) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_port", 32'(rsp_valid), 32'(2'b01 << e.port));
                    chk("rsp_data", rsp_data, e.prod);
                    chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    in_flight = 1'b0;
                end
            end
            exp_rdy = 2'b00;
            if (!in_flight && req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = RR_EN ? pref : 0;
                else g = req_valid[1] ? 1 : 0;
                exp_rdy = 2'b01 << g;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if ((req_ready & req_valid) != 2'b00) begin
                exp_t e;
                op_t  o;
                g = ((req_ready & req_valid) == 2'b10) ? 1 : 0;
                o = (g == 1) ? opq1.pop_front() : opq0.pop_front();
                e.port    = g;
                e.prod    = ref_prod(o.a, o.b);
                e.acc_cyc = cyc;
                e.lat     = LAT + extra;
                sb.push_back(e);
                in_flight    = 1'b1;
                pref         = 1 - g;
                last_acc_cyc = cyc;
                n_accepts++;
                exec_expected++;
                order_log.push_back(g);
                acc_log.push_back(cyc);
            end
        end
        if (mult_execute) begin
            exec_seen++;
            chk("exec_timing", 32'(cyc), 32'(last_acc_cyc + 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((opq0.size() + opq1.size() + sb.size()) != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("drain", 32'(opq0.size() + opq1.size() + sb.size()), 32'd0);
    endtask

    task automatic push(input int port, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        if (port == 0) opq0.push_back(o);
        else opq1.push_back(o);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0, acc0, n0, n1;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_execute", 32'(mult_execute), 32'd0);
        chk("reset_val1", 32'(mult_val1), 32'd0);
        chk("reset_val2", 32'(mult_val2), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        tick();

        // Port 0 alone: 3 * -4.
        push(0, 16'sd3, -16'sd4);
        drain();
        chk("p0_product", rsp_data, 32'hFFFF_FFF4);

        // Port 1 alone: the two extreme operand pairs.
        push(1, -16'sd32768, -16'sd32768);
        drain();
        chk("p1_minmin", rsp_data, 32'h4000_0000);
        push(1, 16'sd32767, 16'sd32767);
        drain();
        chk("p1_maxmax", rsp_data, 32'h3FFF_0001);

        // Both ports valid every cycle.
        order_log.delete();
        acc_log.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, rand_op(), rand_op());
            push(1, rand_op(), rand_op());
        end
        drain();
        chk("grant_count", 32'(order_log.size()), 32'd8);
        for (int i = 0; i < order_log.size() && i < 8; i++) begin
            chk("grant_order", 32'(order_log[i]), RR_EN ? 32'(i % 2) : ((i < 4) ? 32'd0 : 32'd1));
            if (i > 0) chk("accept_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'(LAT));
        end

        // Reset in the middle of a multiply.
        acc0 = n_accepts;
        push(0, 16'($urandom_range(1, 1000)), 16'($urandom_range(1, 1000)));
        n = 0;
        while (n_accepts == acc0 && n < 100) begin
            tick();
            n++;
        end
        chk("abort_accepted", 32'(n_accepts), 32'(acc0 + 1));
        t0 = last_acc_cyc;
        while (cyc < t0 + 20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_execute", 32'(mult_execute), 32'd0);
        chk("abort_val1", 32'(mult_val1), 32'd0);
        chk("abort_val2", 32'(mult_val2), 32'd0);
        tick();
        push(1, 16'sd1234, -16'sd567);
        drain();
        chk("after_abort_product", rsp_data, 32'(-699678));

        // Multiplier that starts three cycles late.
        extra = 3;
        push(1, rand_op(), rand_op());
        drain();
        extra = 0;

        // Random traffic with varying multiplier start latency.
        for (int r = 0; r < 6; r++) begin
            extra = $urandom_range(0, 2);
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) push(0, rand_op(), rand_op());
            for (int k = 0; k < n1; k++) push(1, rand_op(), rand_op());
            drain();
            extra = 0;
        end

        repeat (4) tick();
        chk("exec_count", 32'(exec_seen), 32'(exec_expected));
        chk("rsp_count", 32'(rsp_seen), 32'(n_accepts - aborted));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
